// File: rtl/pe256_grant_scheduler_pkg.sv
// pe256_grant_scheduler_pkg
//   Shared constants for the 256-requester grant scheduler: requester count,
//   grant index width, default counter width, FSM state encoding, and the
//   16-bit highest-set-bit helper used by the encoder lanes.
package pe256_grant_scheduler_pkg;

  localparam int N  = 256;  // requesters == encoder input width
  localparam int W  = 8;    // log2(N)
  localparam int CW = 16;   // default accepted-grant counter width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  // Index of the highest set bit of a 16-bit word; 0 when the word is empty
  // (callers qualify with a separate valid).
  function automatic logic [3:0] hi16(input logic [15:0] x);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (x[i]) r = 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/pe256_scalable.sv
// pe256_scalable
//   256-bit priority encoder, highest index wins.
//   d : request vector
//   q : index of the highest set bit of d (0 when d is empty)
//   v : OR of d
//   Two-level tree: sixteen 16-bit lanes each report a local valid and local
//   index; the highest valid lane then picks which local index is forwarded.
module pe256_scalable
  import pe256_grant_scheduler_pkg::*;
(
  input  logic [N-1:0] d,
  output logic [W-1:0] q,
  output logic         v
);

  localparam int LANE_W = 16;
  localparam int LANES  = N / LANE_W;

  logic [LANES-1:0]      lane_v;
  logic [LANES-1:0][3:0] lane_q;
  logic [3:0]            top_lane;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_v[g] = |d[g*LANE_W +: LANE_W];
    assign lane_q[g] = hi16(d[g*LANE_W +: LANE_W]);
  end

  assign top_lane = hi16(lane_v);
  assign q        = {top_lane, lane_q[top_lane]};
  assign v        = |lane_v;

endmodule

// File: rtl/pe256_grant_scheduler.sv
// pe256_grant_scheduler
//   Arbitrates one shared resource among 256 requesters. Request pulses set
//   sticky pending flags; the highest pending-and-enabled index is offered
//   as a grant with a valid/ready handshake, and its flag clears on accept.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req_in    : one-cycle request pulses, bit i sets pend[i]
//   mask      : per-requester enable (1 = eligible)
//   gnt_ready : consumer accepts the offered grant
//   gnt_valid : grant offered
//   gnt_id    : granted requester index
//   pend      : sticky pending flags
//   busy      : FSM not idle
//   gnt_count : accepted grants, saturating
module pe256_grant_scheduler
  import pe256_grant_scheduler_pkg::*;
#(
  parameter int CW = pe256_grant_scheduler_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  input  logic [N-1:0]  mask,
  input  logic          gnt_ready,
  output logic          gnt_valid,
  output logic [W-1:0]  gnt_id,
  output logic [N-1:0]  pend,
  output logic          busy,
  output logic [CW-1:0] gnt_count
);

  logic [1:0]   state;
  logic [N-1:0] eligible;
  logic [N-1:0] clr;
  logic [W-1:0] enc_q;
  logic         enc_v;
  logic         accept;

  assign eligible = pend & mask;

  pe256_scalable u_pe (
    .d (eligible),
    .q (enc_q),
    .v (enc_v)
  );

  // gnt_ready with no grant on offer is ignored.
  assign accept = gnt_valid & gnt_ready;
  assign clr    = accept ? (N'(1) << gnt_id) : '0;
  assign busy   = (state != ST_IDLE);

  // A request landing on the bit being accepted re-arms it: set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr) | req_in;
  end

  // SEL captures the encoder output straight into gnt_id; gnt_id doubles as
  // the selection register, so the choice reflects pend/mask at the SEL edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      gnt_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (enc_v) state <= ST_SEL;
        ST_SEL: begin
          if (enc_v) begin
            gnt_id    <= enc_q;
            gnt_valid <= 1'b1;
            state     <= ST_GRANT;
          end else begin
            state     <= ST_IDLE;  // everything masked off since IDLE
          end
        end
        ST_GRANT: begin
          // Held regardless of mask changes; an issued grant is never revoked.
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            state     <= ST_IDLE;
            if (gnt_count != '1) gnt_count <= gnt_count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
